// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver with prefix folding and event FIFO
//
// Deserialises 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop),
// folds E0 (extended) and F0 (release) prefixes into flags and queues key
// events in a first-word-fallthrough FIFO.
//
// Ports:
//   clk_sys      in   system clock, the only clock
//   reset_n      in   synchronous active-low reset
//   ps2_clk      in   PS/2 clock (asynchronous, synchronised here)
//   ps2_data     in   PS/2 data (asynchronous, synchronised here)
//   key_valid    out  FIFO non-empty, head event presented
//   key_ready    in   consumer accepts the head event
//   key_code     out  scancode of head event
//   key_ext      out  head event was preceded by E0
//   key_release  out  head event was preceded by F0
//   frame_err    out  one-cycle pulse on parity, stop or timeout error
//   overflow     out  one-cycle pulse when an event is dropped (FIFO full)

module ps2_kbd_rx #(
  parameter int TIMEOUT   = 8000,
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TMO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0]      TMO_ONE = TW'(1);
  localparam logic [FIFO_BITS:0] PTR_ONE = {{FIFO_BITS{1'b0}}, 1'b1};
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers; third clock stage is the edge-detect register.
  // ---------------------------------------------------------------------------
  logic pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic pdat_s1_q, pdat_s2_q;
  logic fall;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pclk_s1_q <= 1'b1;
      pclk_s2_q <= 1'b1;
      pclk_s3_q <= 1'b1;
      pdat_s1_q <= 1'b1;
      pdat_s2_q <= 1'b1;
    end else begin
      pclk_s1_q <= ps2_clk;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      pdat_s1_q <= ps2_data;
      pdat_s2_q <= pdat_s1_q;
    end
  end

  assign fall = pclk_s3_q & ~pclk_s2_q;

  // ---------------------------------------------------------------------------
  // Frame FSM, timeout, prefix flags and FIFO state
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     sr_q, sr_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           byte_stb_q, byte_stb_d;
  logic [7:0]     byte_q, byte_d;
  logic           frame_err_q, frame_err_d;
  logic           ext_q, ext_d;
  logic           rel_q, rel_d;

  logic [FIFO_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [9:0]         mem_q [DEPTH];

  logic err_clear;
  logic push;
  logic pop;
  logic wr_en;
  logic fifo_empty;
  logic fifo_full;
  logic [9:0] head;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      sr_q        <= 8'd0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'd0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Event storage is cleared on reset so the head fields read as zero.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= {ext_q, rel_q, byte_q};
    end
  end

  // Frame FSM next state
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    byte_stb_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    err_clear   = 1'b0;

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          // A high bit in IDLE is not a start bit; ignore it.
          if (!pdat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          sr_d     = {pdat_s2_q, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = pdat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (pdat_s2_q && ((^sr_q) ^ par_q)) begin
            byte_stb_d = 1'b1;
            byte_d     = sr_q;
          end else begin
            frame_err_d = 1'b1;
            err_clear   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      // Bus went quiet mid-frame: abandon it.
      state_d     = ST_IDLE;
      bitcnt_d    = 3'd0;
      tmo_d       = '0;
      frame_err_d = 1'b1;
      err_clear   = 1'b1;
    end else begin
      tmo_d = tmo_q + TMO_ONE;
    end
  end

  // Prefix decoder and FIFO control
  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    push  = 1'b0;

    if (byte_stb_q) begin
      if (byte_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == CODE_REL) begin
        rel_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end

    if (err_clear) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                      (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
  assign pop        = ~fifo_empty & key_ready;
  // A full FIFO still accepts a write when the head leaves on the same cycle.
  assign wr_en      = push & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  assign head        = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
  assign key_valid   = ~fifo_empty;
  assign key_code    = head[7:0];
  assign key_release = head[8];
  assign key_ext     = head[9];
  assign frame_err   = frame_err_q;
  assign overflow    = push & fifo_full & ~pop;

endmodule
